// File: rtl/ctrl_pipe.sv
// Pipeline control: decodes the ID instruction into EX/MEM/WB control fields and
// sequences load-use stalls and taken-branch flushes with a RUN/STALL/FLUSH FSM.
module ctrl_pipe #(
    parameter int unsigned LU_STALL       = 1,
    parameter int unsigned FLUSH_CYCLES   = 2,
    parameter int unsigned EN_UNSIGNED_BR = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_inst,
    input  logic        ex_taken,
    output logic        stall_o,
    output logic        flush_o,
    output logic        illegal_o,
    output logic        ex_valid,
    output logic [1:0]  ex_npc_op,
    output logic        ex_npco_sel,
    output logic [2:0]  ex_sext_op,
    output logic [3:0]  ex_alu_op,
    output logic        ex_alub_sel,
    output logic        mem_valid,
    output logic        mem_dram_we,
    output logic        wb_valid,
    output logic        wb_rf_we,
    output logic [1:0]  wb_rf_wesl,
    output logic [4:0]  wb_rd
);

    localparam int unsigned CNT_W = 2;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_JMP  = 2'b10;
    localparam logic [1:0] NPC_JMPR = 2'b11;

    localparam logic [1:0] WESL_ALU  = 2'b00;
    localparam logic [1:0] WESL_DRAM = 2'b01;
    localparam logic [1:0] WESL_PC4  = 2'b10;
    localparam logic [1:0] WESL_EXT  = 2'b11;

    localparam logic [2:0] SEXT_I = 3'b000;
    localparam logic [2:0] SEXT_S = 3'b001;
    localparam logic [2:0] SEXT_B = 3'b010;
    localparam logic [2:0] SEXT_U = 3'b011;
    localparam logic [2:0] SEXT_J = 3'b100;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_SLL  = 4'h5;
    localparam logic [3:0] ALU_SRL  = 4'h6;
    localparam logic [3:0] ALU_SRA  = 4'h7;
    localparam logic [3:0] ALU_BEQ  = 4'h8;
    localparam logic [3:0] ALU_BNE  = 4'h9;
    localparam logic [3:0] ALU_BLT  = 4'hA;
    localparam logic [3:0] ALU_BGE  = 4'hB;
    localparam logic [3:0] ALU_BLTU = 4'hC;
    localparam logic [3:0] ALU_BGEU = 4'hD;

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_STALL = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    typedef struct packed {
        logic       valid;
        logic [1:0] npc_op;
        logic       npco_sel;
        logic [2:0] sext_op;
        logic [3:0] alu_op;
        logic       alub_sel;
        logic       rf_we;
        logic [1:0] rf_wesl;
        logic       dram_we;
        logic [4:0] rd;
        logic       is_load;
    } ex_t;

    typedef struct packed {
        logic       valid;
        logic       rf_we;
        logic [1:0] rf_wesl;
        logic       dram_we;
        logic [4:0] rd;
    } mem_t;

    typedef struct packed {
        logic       valid;
        logic       rf_we;
        logic [1:0] rf_wesl;
        logic [4:0] rd;
    } wb_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd, rs1, rs2;
    logic       alt;

    assign opcode = id_inst[6:0];
    assign rd     = id_inst[11:7];
    assign funct3 = id_inst[14:12];
    assign rs1    = id_inst[19:15];
    assign rs2    = id_inst[24:20];
    assign alt    = (id_inst[31:25] == F7_ALT);

    ex_t        ex_q, ex_d, dec;
    mem_t       mem_q;
    wb_t        wb_q;
    logic       dec_ok, arith_ok, br_ok, illegal_q;
    logic [3:0] arith_op, br_op;

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             issue, hazard, uses_rs2;

    // Instruction decode into the EX payload
    always_comb begin
        dec      = '0;
        dec_ok   = 1'b0;
        arith_op = ALU_ADD;
        arith_ok = 1'b1;
        br_op    = ALU_BEQ;
        br_ok    = 1'b1;
        case (funct3)
            3'b000:  arith_op = (opcode == OP_R && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  arith_op = ALU_SLL;
            3'b100:  arith_op = ALU_XOR;
            3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  arith_op = ALU_OR;
            3'b111:  arith_op = ALU_AND;
            default: arith_ok = 1'b0;
        endcase
        case (funct3)
            3'b000:  br_op = ALU_BEQ;
            3'b001:  br_op = ALU_BNE;
            3'b100:  br_op = ALU_BLT;
            3'b101:  br_op = ALU_BGE;
            3'b110:  begin br_op = ALU_BLTU; br_ok = (EN_UNSIGNED_BR != 0); end
            3'b111:  begin br_op = ALU_BGEU; br_ok = (EN_UNSIGNED_BR != 0); end
            default: br_ok = 1'b0;
        endcase
        dec.rd = rd;
        case (opcode)
            OP_R, OP_I: begin
                dec_ok       = arith_ok;
                dec.npc_op   = NPC_PC4;
                dec.sext_op  = SEXT_I;
                dec.alu_op   = arith_op;
                dec.alub_sel = (opcode == OP_I);
                dec.rf_we    = 1'b1;
                dec.rf_wesl  = WESL_ALU;
            end
            OP_LOAD: begin
                dec_ok       = 1'b1;
                dec.sext_op  = SEXT_I;
                dec.alub_sel = 1'b1;
                dec.rf_we    = 1'b1;
                dec.rf_wesl  = WESL_DRAM;
                dec.is_load  = 1'b1;
            end
            OP_JALR: begin
                dec_ok       = 1'b1;
                dec.npc_op   = NPC_JMPR;
                dec.npco_sel = 1'b1;
                dec.sext_op  = SEXT_I;
                dec.alub_sel = 1'b1;
                dec.rf_we    = 1'b1;
                dec.rf_wesl  = WESL_PC4;
            end
            OP_S: begin
                dec_ok       = 1'b1;
                dec.sext_op  = SEXT_S;
                dec.alub_sel = 1'b1;
                dec.dram_we  = 1'b1;
            end
            OP_B: begin
                dec_ok      = br_ok;
                dec.npc_op  = NPC_BR;
                dec.sext_op = SEXT_B;
                dec.alu_op  = br_op;
            end
            OP_LUI: begin
                dec_ok      = 1'b1;
                dec.sext_op = SEXT_U;
                dec.rf_we   = 1'b1;
                dec.rf_wesl = WESL_EXT;
            end
            OP_JAL: begin
                dec_ok      = 1'b1;
                dec.npc_op  = NPC_JMP;
                dec.sext_op = SEXT_J;
                dec.rf_we   = 1'b1;
                dec.rf_wesl = WESL_PC4;
            end
            default: dec_ok = 1'b0;
        endcase
        dec.valid = dec_ok;
    end

    // Load-use: the load in EX writes a register the ID instruction reads
    assign uses_rs2 = (opcode == OP_R) || (opcode == OP_S) || (opcode == OP_B);
    assign hazard   = ex_q.valid && ex_q.is_load && (ex_q.rd != 5'd0) &&
                      ((ex_q.rd == rs1) || (uses_rs2 && (ex_q.rd == rs2)));

    // Next-state, stall/flush and issue decision
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall_o   = 1'b0;
        flush_o   = 1'b0;
        issue     = 1'b0;
        if (rst) begin
            state_nxt = S_RUN;
            cnt_nxt   = '0;
        end else if (ex_taken) begin
            state_nxt = S_FLUSH;
            cnt_nxt   = CNT_W'(FLUSH_CYCLES - 1);
            flush_o   = 1'b1;
        end else if (state != S_RUN && cnt != '0) begin
            cnt_nxt = cnt - CNT_W'(1);
            stall_o = (state == S_STALL);
            flush_o = (state == S_FLUSH);
        end else if (hazard) begin
            state_nxt = S_STALL;
            cnt_nxt   = CNT_W'(LU_STALL - 1);
            stall_o   = 1'b1;
        end else begin
            state_nxt = S_RUN;
            cnt_nxt   = '0;
            issue     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign ex_d = (issue && id_valid && dec_ok) ? dec : '0;

    // Stage registers advance unconditionally; stalls and flushes only inject bubbles
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            ex_q      <= ex_d;
            mem_q     <= '{valid: ex_q.valid, rf_we: ex_q.rf_we, rf_wesl: ex_q.rf_wesl,
                           dram_we: ex_q.dram_we, rd: ex_q.rd};
            wb_q      <= '{valid: mem_q.valid, rf_we: mem_q.rf_we, rf_wesl: mem_q.rf_wesl,
                           rd: mem_q.rd};
            illegal_q <= issue && id_valid && !dec_ok;
        end
    end

    assign illegal_o   = illegal_q;
    assign ex_valid    = ex_q.valid;
    assign ex_npc_op   = ex_q.npc_op;
    assign ex_npco_sel = ex_q.npco_sel;
    assign ex_sext_op  = ex_q.sext_op;
    assign ex_alu_op   = ex_q.alu_op;
    assign ex_alub_sel = ex_q.alub_sel;
    assign mem_valid   = mem_q.valid;
    assign mem_dram_we = mem_q.dram_we;
    assign wb_valid    = wb_q.valid;
    assign wb_rf_we    = wb_q.rf_we;
    assign wb_rf_wesl  = wb_q.rf_wesl;
    assign wb_rd       = wb_q.rd;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: two parameterisations driven in lockstep, checked against a
// bubble-count pipeline model plus directed scenarios.
module tb_ctrl_pipe;

    typedef struct packed {
        logic       valid;
        logic [1:0] npc;
        logic       npco;
        logic [2:0] sext;
        logic [3:0] alu;
        logic       alub;
        logic       rf_we;
        logic [1:0] wesl;
        logic       dram_we;
        logic [4:0] rd;
        logic       is_load;
    } stage_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, id_valid, ex_taken;
    logic [31:0] id_inst;

    logic       stall_o [2], flush_o [2], illegal_o [2], ex_valid [2], ex_npco_sel [2];
    logic       ex_alub_sel [2], mem_valid [2], mem_dram_we [2], wb_valid [2], wb_rf_we [2];
    logic [1:0] ex_npc_op [2], wb_rf_wesl [2];
    logic [2:0] ex_sext_op [2];
    logic [3:0] ex_alu_op [2];
    logic [4:0] wb_rd [2];

    int lu_p [2] = '{2, 1};
    int fc_p [2] = '{2, 3};
    int en_p [2] = '{0, 1};

    ctrl_pipe #(.LU_STALL(2), .FLUSH_CYCLES(2), .EN_UNSIGNED_BR(0)) dut0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst), .ex_taken(ex_taken),
        .stall_o(stall_o[0]), .flush_o(flush_o[0]), .illegal_o(illegal_o[0]),
        .ex_valid(ex_valid[0]), .ex_npc_op(ex_npc_op[0]), .ex_npco_sel(ex_npco_sel[0]),
        .ex_sext_op(ex_sext_op[0]), .ex_alu_op(ex_alu_op[0]), .ex_alub_sel(ex_alub_sel[0]),
        .mem_valid(mem_valid[0]), .mem_dram_we(mem_dram_we[0]),
        .wb_valid(wb_valid[0]), .wb_rf_we(wb_rf_we[0]), .wb_rf_wesl(wb_rf_wesl[0]), .wb_rd(wb_rd[0]));

    ctrl_pipe #(.LU_STALL(1), .FLUSH_CYCLES(3), .EN_UNSIGNED_BR(1)) dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst), .ex_taken(ex_taken),
        .stall_o(stall_o[1]), .flush_o(flush_o[1]), .illegal_o(illegal_o[1]),
        .ex_valid(ex_valid[1]), .ex_npc_op(ex_npc_op[1]), .ex_npco_sel(ex_npco_sel[1]),
        .ex_sext_op(ex_sext_op[1]), .ex_alu_op(ex_alu_op[1]), .ex_alub_sel(ex_alub_sel[1]),
        .mem_valid(mem_valid[1]), .mem_dram_we(mem_dram_we[1]),
        .wb_valid(wb_valid[1]), .wb_rf_we(wb_rf_we[1]), .wb_rf_wesl(wb_rf_wesl[1]), .wb_rd(wb_rd[1]));

    int checks = 0;
    int errors = 0;

    // Reference state: what sits in each stage, plus bubbles still owed
    stage_t m_ex [2], m_mem [2], m_wb [2];
    int     stall_left [2], flush_left [2];
    bit     m_ill [2], m_acc [2], m_haz [2];
    bit     m_live = 1'b0;
    logic   last_stall [2], last_flush [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic stage_t ref_decode(input logic [31:0] inst, input int en_u);
        stage_t s = '0;
        bit ok = 1'b1;
        logic [6:0] op = inst[6:0];
        logic [2:0] f3 = inst[14:12];
        bit alt = (inst[31:25] == 7'b0100000);
        s.rd = inst[11:7];
        case (op)
            7'h33, 7'h13: begin
                s.rf_we = 1'b1;
                s.alub  = (op == 7'h13);
                case (f3)
                    3'd0: s.alu = (alt && op == 7'h33) ? 4'd1 : 4'd0;
                    3'd1: s.alu = 4'd5;
                    3'd4: s.alu = 4'd4;
                    3'd5: s.alu = alt ? 4'd7 : 4'd6;
                    3'd6: s.alu = 4'd3;
                    3'd7: s.alu = 4'd2;
                    default: ok = 1'b0;
                endcase
            end
            7'h03: begin s.rf_we = 1'b1; s.wesl = 2'd1; s.alub = 1'b1; s.is_load = 1'b1; end
            7'h67: begin s.npc = 2'd3; s.npco = 1'b1; s.alub = 1'b1; s.rf_we = 1'b1; s.wesl = 2'd2; end
            7'h23: begin s.sext = 3'd1; s.alub = 1'b1; s.dram_we = 1'b1; end
            7'h63: begin
                s.npc  = 2'd1;
                s.sext = 3'd2;
                case (f3)
                    3'd0: s.alu = 4'h8;
                    3'd1: s.alu = 4'h9;
                    3'd4: s.alu = 4'hA;
                    3'd5: s.alu = 4'hB;
                    3'd6: begin s.alu = 4'hC; ok = (en_u != 0); end
                    3'd7: begin s.alu = 4'hD; ok = (en_u != 0); end
                    default: ok = 1'b0;
                endcase
            end
            7'h37: begin s.sext = 3'd3; s.rf_we = 1'b1; s.wesl = 2'd3; end
            7'h6f: begin s.npc = 2'd2; s.sext = 3'd4; s.rf_we = 1'b1; s.wesl = 2'd2; end
            default: ok = 1'b0;
        endcase
        s.valid = ok;
        return ok ? s : stage_t'(0);
    endfunction

    function automatic bit ref_hazard(input stage_t ex, input logic [31:0] inst);
        logic [6:0] op = inst[6:0];
        bit rs2_used = (op == 7'h33) || (op == 7'h23) || (op == 7'h63);
        if (!(ex.valid && ex.is_load && ex.rd != 5'd0)) return 1'b0;
        return (ex.rd == inst[19:15]) || (rs2_used && ex.rd == inst[24:20]);
    endfunction

    // One clock: check combinational outputs mid-cycle, advance model, check registers
    task automatic tick();
        bit st, fl;
        stage_t dec;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            st = 1'b0; fl = 1'b0; m_acc[d] = 1'b0;
            m_haz[d] = ref_hazard(m_ex[d], id_inst);
            if (rst)                  ;
            else if (ex_taken)        fl = 1'b1;
            else if (flush_left[d] > 0) fl = 1'b1;
            else if (stall_left[d] > 0) st = 1'b1;
            else if (m_haz[d])        st = 1'b1;
            else                      m_acc[d] = 1'b1;
            last_stall[d] = stall_o[d];
            last_flush[d] = flush_o[d];
            if (m_live) begin
                chk($sformatf("stall%0d", d), 32'(stall_o[d]), 32'(st));
                chk($sformatf("flush%0d", d), 32'(flush_o[d]), 32'(fl));
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_ex[d] = '0; m_mem[d] = '0; m_wb[d] = '0; m_ill[d] = 1'b0;
                stall_left[d] = 0; flush_left[d] = 0;
            end else begin
                dec = ref_decode(id_inst, en_p[d]);
                m_wb[d]  = m_mem[d];
                m_mem[d] = m_ex[d];
                m_ex[d]  = (m_acc[d] && id_valid) ? dec : stage_t'(0);
                m_ill[d] = m_acc[d] && id_valid && !dec.valid;
                if (ex_taken) begin
                    flush_left[d] = fc_p[d] - 1; stall_left[d] = 0;
                end else if (flush_left[d] > 0) flush_left[d]--;
                else if (stall_left[d] > 0)     stall_left[d]--;
                else if (m_haz[d])              stall_left[d] = lu_p[d] - 1;
            end
        end
        if (rst) m_live = 1'b1;
        if (m_live) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("ex%0d", d),
                    32'({ex_valid[d], ex_npc_op[d], ex_npco_sel[d], ex_sext_op[d], ex_alu_op[d], ex_alub_sel[d]}),
                    32'({m_ex[d].valid, m_ex[d].npc, m_ex[d].npco, m_ex[d].sext, m_ex[d].alu, m_ex[d].alub}));
                chk($sformatf("mem%0d", d), 32'({mem_valid[d], mem_dram_we[d]}),
                    32'({m_mem[d].valid, m_mem[d].dram_we}));
                chk($sformatf("wb%0d", d), 32'({wb_valid[d], wb_rf_we[d], wb_rf_wesl[d], wb_rd[d]}),
                    32'({m_wb[d].valid, m_wb[d].rf_we, m_wb[d].wesl, m_wb[d].rd}));
                chk($sformatf("illegal%0d", d), 32'(illegal_o[d]), 32'(m_ill[d]));
            end
        end
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h6f, 7'h0f, 7'h00};
        logic [6:0] op = ops[$urandom_range(0, 9)];
        logic [6:0] f7 = ($urandom_range(0, 2) == 0) ? 7'($urandom) : (($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20);
        if (op == 7'h00) op = 7'($urandom);
        return {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom),
                5'($urandom_range(0, 3)), op};
    endfunction

    localparam logic [31:0] LW_X5  = 32'h0000A283;
    localparam logic [31:0] ADD_X6 = 32'h00128333;
    localparam logic [31:0] ADDI   = 32'h00108093;

    initial begin
        logic [31:0] bltu;
        bltu = {7'd0, 5'd2, 5'd1, 3'b110, 5'd8, 7'b1100011};
        rst = 1'b1; id_valid = 1'b0; ex_taken = 1'b0; id_inst = '0;
        tick(); tick();
        chk("reset_ex_valid", 32'(ex_valid[0]), 32'd0);
        chk("reset_wb_valid", 32'(wb_valid[1]), 32'd0);
        chk("reset_illegal", 32'(illegal_o[0]), 32'd0);
        rst = 1'b0;

        // sub x2,x1,x2 flows through to WB two cycles after EX
        id_valid = 1'b1; id_inst = 32'h40208133;
        tick();
        chk("sub_alu_op", 32'(ex_alu_op[0]), 32'd1);
        chk("sub_alub", 32'(ex_alub_sel[0]), 32'd0);
        id_valid = 1'b0;
        tick(); tick();
        chk("sub_wb_we", 32'(wb_rf_we[0]), 32'd1);
        chk("sub_wb_wesl", 32'(wb_rf_wesl[0]), 32'd0);
        chk("sub_wb_rd", 32'(wb_rd[0]), 32'd2);

        // lw x5 then add x6,x5,x1: two stall cycles on the LU_STALL=2 instance
        id_valid = 1'b1; id_inst = LW_X5;
        tick();
        id_inst = ADD_X6;
        tick();
        chk("lu_stall_a", 32'(last_stall[0]), 32'd1);
        chk("lu_bubble_a", 32'(ex_valid[0]), 32'd0);
        tick();
        chk("lu_stall_b", 32'(last_stall[0]), 32'd1);
        chk("lu_bubble_b", 32'(ex_valid[0]), 32'd0);
        tick();
        chk("lu_release", 32'(last_stall[0]), 32'd0);
        chk("lu_issue", 32'(ex_valid[0]), 32'd1);
        id_valid = 1'b0;
        tick(); tick();

        // Taken branch with FLUSH_CYCLES=2
        id_valid = 1'b1; id_inst = ADDI; ex_taken = 1'b1;
        tick();
        chk("fl_a", 32'(last_flush[0]), 32'd1);
        chk("fl_bubble_a", 32'(ex_valid[0]), 32'd0);
        ex_taken = 1'b0;
        tick();
        chk("fl_b", 32'(last_flush[0]), 32'd1);
        chk("fl_bubble_b", 32'(ex_valid[0]), 32'd0);
        tick();
        chk("fl_done", 32'(last_flush[0]), 32'd0);
        chk("fl_resume", 32'(ex_valid[0]), 32'd1);

        // Taken branch wins over a simultaneous load-use hazard
        id_inst = LW_X5;
        tick();
        id_inst = ADD_X6; ex_taken = 1'b1;
        tick();
        chk("prio_stall", 32'(last_stall[0]), 32'd0);
        chk("prio_flush", 32'(last_flush[0]), 32'd1);
        ex_taken = 1'b0; id_valid = 1'b0;
        tick(); tick(); tick();

        // BLTU: illegal without unsigned branches, decoded with them
        id_valid = 1'b1; id_inst = bltu;
        tick();
        chk("bltu_illegal", 32'(illegal_o[0]), 32'd1);
        chk("bltu_bubble", 32'(ex_valid[0]), 32'd0);
        chk("bltu_alu", 32'(ex_alu_op[1]), 32'hC);
        chk("bltu_npc", 32'(ex_npc_op[1]), 32'd1);
        id_valid = 1'b0;
        tick();
        chk("illegal_pulse", 32'(illegal_o[0]), 32'd0);

        // Reset in the middle of a stall
        id_valid = 1'b1; id_inst = LW_X5;
        tick();
        id_inst = ADD_X6;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_ex", 32'(ex_valid[0]), 32'd0);
        chk("rst_mem", 32'(mem_valid[0]), 32'd0);
        chk("rst_wb", 32'(wb_valid[0]), 32'd0);
        tick();
        chk("rst_stall", 32'(last_stall[0]), 32'd0);

        // Randomised traffic against the model
        for (int i = 0; i < 800; i++) begin
            rst      = ($urandom_range(0, 99) == 0);
            ex_taken = ($urandom_range(0, 7) == 0);
            id_valid = ($urandom_range(0, 7) != 0);
            id_inst  = rand_inst();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 Parameter LU_STALL, default 1, load-use bubbles inserted per hazard (legal 1..3).
REQ-002 Parameter FLUSH_CYCLES, default 2, bubbles inserted after a taken branch/jump (legal 1..3).
REQ-003 Parameter EN_UNSIGNED_BR, default 0, 1 = decode BLTU (funct3 110) / BGEU (funct3 111).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 id_valid  in  1  ID holds a valid instruction.
REQ-007 id_inst  in  32  instruction in ID; opcode [6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20], funct7 [31:25].
REQ-008 ex_taken  in  1  EX resolved a taken branch, JAL or JALR this cycle.
REQ-009 stall_o  out  1  hold PC and IF/ID.
REQ-010 flush_o  out  1  squash IF/ID.
REQ-011 illegal_o  out  1  one-cycle pulse: unsupported opcode accepted from ID.
REQ-012 ex_valid, ex_npc_op[1:0], ex_npco_sel, ex_sext_op[2:0], ex_alu_op[3:0], ex_alub_sel  out  EX-stage control.
REQ-013 mem_valid, mem_dram_we  out  MEM-stage control.
REQ-014 wb_valid, wb_rf_we, wb_rf_wesl[1:0], wb_rd[4:0]  out  WB-stage control.

Function
REQ-015 Encodings: npc_op PC4=00, BR=01, JMP=10, JMPR=11; rf_wesl ALU=00, DRAM=01, PC4=10, EXT=11; sext_op I=000, S=001, B=010, U=011, J=100.
REQ-016 alu_op: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, BEQ 8, BNE 9, BLT A, BGE B, BLTU C, BGEU D.
REQ-017 Supported opcodes: R 0110011, I 0010011, LOAD 0000011, JALR 1100111, S 0100011, B 1100011, LUI 0110111, JAL 1101111; any other is illegal.
REQ-018 R/I: funct3 picks the op; funct7=0100000 selects SUB (R only) and SRA (R and I); funct3 010/011 are illegal.
REQ-019 B: funct3 000/001/100/101 give BEQ/BNE/BLT/BGE; 110/111 give BLTU/BGEU only when EN_UNSIGNED_BR=1, otherwise illegal; 010/011 are always illegal.
REQ-020 npco_sel=1 for JALR only; alub_sel=1 (immediate) for I, LOAD, JALR, S; rf_we=0 for S and B; dram_we=1 for S only.
REQ-021 Every other field takes the per-opcode mapping given in REQ-015 to REQ-020; non-branch alu_op = ADD.
REQ-022 A bubble is: valid=0, every write enable 0, npc_op=PC4, every other field 0.
REQ-023 Stage registers ID->EX->MEM->WB advance every cycle, so WB trails EX by exactly 2 cycles.
REQ-024 An illegal or !id_valid instruction enters EX as a bubble; illegal_o asserts only when id_valid=1 in RUN.
REQ-025 FSM states RUN, STALL, FLUSH; reset state RUN.
REQ-026 Load-use hazard = ex_valid, EX opcode LOAD, EX rd!=0, and (rd==rs1, or rd==rs2 where ID opcode is R/S/B).
REQ-027 RUN + hazard: STALL with counter=LU_STALL-1; a bubble enters EX; stall_o=1 combinationally in the detect cycle and throughout STALL.
REQ-028 STALL: a bubble enters EX each cycle; at counter=0, go to RUN with stall_o=0, so the held instruction issues on the next edge.
REQ-029 ex_taken in any state: FLUSH with counter=FLUSH_CYCLES-1; flush_o=1 in that cycle and throughout FLUSH; bubbles enter EX; stall_o=0.
REQ-030 ex_taken has priority over a load-use hazard and aborts STALL.
REQ-031 FLUSH: at counter=0, go to RUN; ex_taken arriving during FLUSH reloads the counter.
REQ-032 EX/MEM/WB contents already issued are never squashed by flush or stall.

Reset
REQ-033 rst=1 on an edge: state RUN, counters 0, all stage registers take bubble values, stall_o=0, flush_o=0, illegal_o=0.
REQ-034 Reset overrides ex_taken, hazards and id_valid in the same cycle; outputs hold bubble values until rst=0.

Verification
REQ-035 R-type 0x40208133 (sub x2,x1,x2) valid -> next cycle ex_alu_op=1, ex_alub_sel=0; two cycles later wb_rf_we=1, wb_rf_wesl=00, wb_rd=2.
REQ-036 lw x5 then add x6,x5,x1 with LU_STALL=2 -> stall_o=1 for 2 cycles, 2 EX bubbles, then add issues with ex_valid=1.
REQ-037 ex_taken pulse with FLUSH_CYCLES=2 -> flush_o=1 for 2 cycles, 2 EX bubbles, then RUN resumes.
REQ-038 ex_taken in the same cycle as a load-use hazard -> FLUSH entered, stall_o=0, flush_o=1.
REQ-039 BLTU (funct3 110) with EN_UNSIGNED_BR=0 -> illegal_o pulses and a bubble enters EX; with EN_UNSIGNED_BR=1 -> ex_alu_op=C, ex_npc_op=01.
REQ-040 rst asserted mid-STALL -> next cycle state RUN, all stage valids 0, stall_o=0.
